// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM data-port arbiter: owner IDs carried by the
// response-routing FIFO and the default starvation limit.
package ram_arb_pkg;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_DBG  = 1'b1
  } owner_e;

  localparam int DEFAULT_MAX_WAIT = 8;

endpackage

// File: rtl/ram_arb_owner_fifo.sv
// Circular buffer of owner IDs, one entry per outstanding RAM request.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ram_arb_owner_fifo
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  owner_e wdata,
  output owner_e rdata,
  output logic   full,
  output logic   empty
);

  localparam int PW = $clog2(DEPTH);

  owner_e         mem_q [DEPTH];
  logic   [PW:0]  wr_ptr_q;
  logic   [PW:0]  rd_ptr_q;
  logic           push_en;
  logic           pop_en;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign rdata   = mem_q[rd_ptr_q[PW-1:0]];

  // A push into a full buffer is only legal when the head leaves this cycle.
  assign push_en = push && (!full || pop);
  assign pop_en  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; entries are only read once the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ram_data_arbiter.sv
// Two-master arbiter for the RAM data port: core LSU has fixed priority,
// the debug/loader master is protected by a starvation counter.
module ram_data_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 22,
  parameter int MAX_WAIT   = DEFAULT_MAX_WAIT,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [31:0]           m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  err_o
);

  localparam int             WW         = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]  WAIT_LIMIT = WW'(MAX_WAIT);

  logic [WW-1:0] wait_q;
  owner_e        sel;
  owner_e        head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          pop;
  logic          err_q;

  assign sel = (m1_req_i && (!m0_req_i || wait_q == WAIT_LIMIT)) ? OWNER_DBG : OWNER_CORE;

  // A response in the same cycle frees a slot, so a full FIFO does not stall the request.
  assign mem_req_o = (m0_req_i || m1_req_i) && (!fifo_full || mem_rvalid_i);
  assign accept    = mem_req_o && mem_gnt_i;
  assign m0_gnt_o  = accept && (sel == OWNER_CORE);
  assign m1_gnt_o  = accept && (sel == OWNER_DBG);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (sel == OWNER_DBG) begin
        mem_addr_o  = m1_addr_i;
        mem_we_o    = m1_we_i;
        mem_be_o    = m1_be_i;
        mem_wdata_o = m1_wdata_i;
      end else begin
        mem_addr_o  = m0_addr_i;
        mem_we_o    = m0_we_i;
        mem_be_o    = m0_be_i;
        mem_wdata_o = m0_wdata_i;
      end
    end
  end

  assign pop         = mem_rvalid_i && !fifo_empty;
  assign m0_rvalid_o = pop && (head == OWNER_CORE);
  assign m1_rvalid_o = pop && (head == OWNER_DBG);
  assign m0_rdata_o  = mem_rdata_i;
  assign m1_rdata_o  = mem_rdata_i;
  assign err_o       = err_q;

  ram_arb_owner_fifo #(
    .DEPTH (DEPTH)
  ) u_owner_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .wdata (sel),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (!m1_req_i || m1_gnt_o) begin
        wait_q <= '0;
      end else if (wait_q != WAIT_LIMIT) begin
        wait_q <= wait_q + WW'(1);
      end
      if (mem_rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_data_arbiter.sv
// Directed bench for ram_data_arbiter: a vector table for single-cycle
// behaviour plus sequences for starvation, stray responses and reset.
module tb_ram_data_arbiter;

  localparam logic        H   = 1'b1;
  localparam logic        L   = 1'b0;
  localparam logic [3:0]  BF  = 4'hF;
  localparam logic [3:0]  B0  = 4'h0;
  localparam logic [21:0] Z22 = 22'h0;
  localparam logic [31:0] Z32 = 32'h0;
  localparam logic [31:0] W0  = 32'hAAAA_0000;
  localparam logic [31:0] W1  = 32'h5555_0000;

  logic        clk;
  logic        rst_n;
  logic        m0_req_i, m1_req_i;
  logic [21:0] m0_addr_i, m1_addr_i;
  logic        m0_we_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [31:0] m0_wdata_i, m1_wdata_i;
  logic        m0_gnt_o, m1_gnt_o;
  logic        m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        mem_req_o;
  logic [21:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        m0_req;
    logic        m1_req;
    logic [21:0] m0_addr;
    logic [21:0] m1_addr;
    logic        m1_we;
    logic [3:0]  m1_be;
    logic [31:0] m1_wdata;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        x_req;
    logic        x_g0;
    logic        x_g1;
    logic        x_rv0;
    logic        x_rv1;
    logic [21:0] x_addr;
    logic        x_we;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
    logic        x_err;
  } vec_t;

  vec_t vecs [18];

  ram_data_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_req_i     (m0_req_i),
    .m0_addr_i    (m0_addr_i),
    .m0_we_i      (m0_we_i),
    .m0_be_i      (m0_be_i),
    .m0_wdata_i   (m0_wdata_i),
    .m0_gnt_o     (m0_gnt_o),
    .m0_rvalid_o  (m0_rvalid_o),
    .m0_rdata_o   (m0_rdata_o),
    .m1_req_i     (m1_req_i),
    .m1_addr_i    (m1_addr_i),
    .m1_we_i      (m1_we_i),
    .m1_be_i      (m1_be_i),
    .m1_wdata_i   (m1_wdata_i),
    .m1_gnt_o     (m1_gnt_o),
    .m1_rvalid_o  (m1_rvalid_o),
    .m1_rdata_o   (m1_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    m0_req_i     = 1'b0;
    m1_req_i     = 1'b0;
    m0_addr_i    = '0;
    m1_addr_i    = '0;
    m0_we_i      = 1'b0;
    m1_we_i      = 1'b0;
    m0_be_i      = BF;
    m1_be_i      = BF;
    m0_wdata_i   = W0;
    m1_wdata_i   = W1;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic apply_vec(input int i, input vec_t v);
    @(negedge clk);
    m0_req_i     = v.m0_req;
    m1_req_i     = v.m1_req;
    m0_addr_i    = v.m0_addr;
    m1_addr_i    = v.m1_addr;
    m1_we_i      = v.m1_we;
    m1_be_i      = v.m1_be;
    m1_wdata_i   = v.m1_wdata;
    mem_gnt_i    = v.gnt;
    mem_rvalid_i = v.rv;
    mem_rdata_i  = v.rdata;
    #2;
    check($sformatf("v%0d mem_req", i), 32'(mem_req_o), 32'(v.x_req));
    check($sformatf("v%0d m0_gnt", i), 32'(m0_gnt_o), 32'(v.x_g0));
    check($sformatf("v%0d m1_gnt", i), 32'(m1_gnt_o), 32'(v.x_g1));
    check($sformatf("v%0d m0_rvalid", i), 32'(m0_rvalid_o), 32'(v.x_rv0));
    check($sformatf("v%0d m1_rvalid", i), 32'(m1_rvalid_o), 32'(v.x_rv1));
    check($sformatf("v%0d mem_addr", i), 32'(mem_addr_o), 32'(v.x_addr));
    check($sformatf("v%0d mem_we", i), 32'(mem_we_o), 32'(v.x_we));
    check($sformatf("v%0d mem_be", i), 32'(mem_be_o), 32'(v.x_be));
    check($sformatf("v%0d mem_wdata", i), mem_wdata_o, v.x_wdata);
    check($sformatf("v%0d m0_rdata", i), m0_rdata_o, v.rdata);
    check($sformatf("v%0d m1_rdata", i), m1_rdata_o, v.rdata);
    check($sformatf("v%0d err", i), 32'(err_o), 32'(v.x_err));
  endtask

  initial begin
    logic exp_g0, exp_g1, exp_rv0, exp_rv1;

    vecs[0]  = '{H,L,22'h100,Z22,L,BF,W1,H,L,Z32,          H,H,L,L,L,22'h100,L,BF,W0,L};
    vecs[1]  = '{L,L,Z22,Z22,L,BF,W1,L,H,32'hDEADBEEF,     L,L,L,H,L,Z22,L,B0,Z32,L};
    vecs[2]  = '{H,L,22'h010,Z22,L,BF,W1,H,L,Z32,          H,H,L,L,L,22'h010,L,BF,W0,L};
    vecs[3]  = '{L,H,Z22,22'h020,L,BF,W1,H,H,32'h11111111, H,L,H,H,L,22'h020,L,BF,W1,L};
    vecs[4]  = '{L,L,Z22,Z22,L,BF,W1,L,H,32'h22222222,     L,L,L,L,H,Z22,L,B0,Z32,L};
    vecs[5]  = '{L,L,Z22,Z22,L,BF,W1,L,L,Z32,              L,L,L,L,L,Z22,L,B0,Z32,L};
    vecs[6]  = '{L,H,Z22,22'h044,H,4'h3,32'h12345678,H,L,Z32, H,L,H,L,L,22'h044,H,4'h3,32'h12345678,L};
    vecs[7]  = '{L,L,Z22,Z22,L,BF,W1,L,H,32'h00000007,     L,L,L,L,H,Z22,L,B0,Z32,L};
    vecs[8]  = '{H,L,22'h200,Z22,L,BF,W1,H,L,Z32,          H,H,L,L,L,22'h200,L,BF,W0,L};
    vecs[9]  = '{H,L,22'h204,Z22,L,BF,W1,H,L,Z32,          H,H,L,L,L,22'h204,L,BF,W0,L};
    vecs[10] = '{H,L,22'h208,Z22,L,BF,W1,H,L,Z32,          L,L,L,L,L,Z22,L,B0,Z32,L};
    vecs[11] = '{H,L,22'h208,Z22,L,BF,W1,H,H,32'h33333333, H,H,L,H,L,22'h208,L,BF,W0,L};
    vecs[12] = '{L,L,Z22,Z22,L,BF,W1,L,H,32'h44444444,     L,L,L,H,L,Z22,L,B0,Z32,L};
    vecs[13] = '{L,L,Z22,Z22,L,BF,W1,L,H,32'h55555555,     L,L,L,H,L,Z22,L,B0,Z32,L};
    vecs[14] = '{L,L,Z22,Z22,L,BF,W1,L,L,Z32,              L,L,L,L,L,Z22,L,B0,Z32,L};
    vecs[15] = '{H,H,22'h300,22'h304,L,BF,W1,L,L,Z32,      H,L,L,L,L,22'h300,L,BF,W0,L};
    vecs[16] = '{L,H,Z22,22'h304,L,BF,W1,L,L,Z32,          H,L,L,L,L,22'h304,L,BF,W1,L};
    vecs[17] = '{L,L,Z22,Z22,L,BF,W1,L,L,Z32,              L,L,L,L,L,Z22,L,B0,Z32,L};

    idle();
    rst_n = 1'b0;
    #3;
    check("reset mem_req", 32'(mem_req_o), 32'd0);
    check("reset m0_gnt", 32'(m0_gnt_o), 32'd0);
    check("reset m1_gnt", 32'(m1_gnt_o), 32'd0);
    check("reset m0_rvalid", 32'(m0_rvalid_o), 32'd0);
    check("reset m1_rvalid", 32'(m1_rvalid_o), 32'd0);
    check("reset mem_addr", 32'(mem_addr_o), 32'd0);
    check("reset err", 32'(err_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) apply_vec(i, vecs[i]);

    // Both masters request every cycle; the RAM answers each grant one cycle later.
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      m0_req_i     = (c < 10);
      m1_req_i     = (c < 10);
      m0_addr_i    = 22'(c * 4);
      m1_addr_i    = 22'h400;
      m1_we_i      = 1'b0;
      m1_be_i      = BF;
      m1_wdata_i   = W1;
      mem_gnt_i    = (c < 10);
      mem_rvalid_i = (c > 0);
      mem_rdata_i  = 32'(c);
      exp_g1  = (c == 8);
      exp_g0  = (c < 10) && !exp_g1;
      exp_rv1 = (c == 9);
      exp_rv0 = (c > 0) && !exp_rv1;
      #2;
      check($sformatf("starve c%0d m0_gnt", c), 32'(m0_gnt_o), 32'(exp_g0));
      check($sformatf("starve c%0d m1_gnt", c), 32'(m1_gnt_o), 32'(exp_g1));
      check($sformatf("starve c%0d m0_rvalid", c), 32'(m0_rvalid_o), 32'(exp_rv0));
      check($sformatf("starve c%0d m1_rvalid", c), 32'(m1_rvalid_o), 32'(exp_rv1));
      if (exp_g1) check("starve m1 addr", 32'(mem_addr_o), 32'h400);
    end

    // Stray response with nothing outstanding.
    do_reset();
    @(negedge clk);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hBAD0_0001;
    #2;
    check("stray m0_rvalid", 32'(m0_rvalid_o), 32'd0);
    check("stray m1_rvalid", 32'(m1_rvalid_o), 32'd0);
    check("stray err same cycle", 32'(err_o), 32'd0);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #2;
    check("stray err next cycle", 32'(err_o), 32'd1);
    @(negedge clk);
    #2;
    check("stray err sticky", 32'(err_o), 32'd1);

    // Reset with one request in flight; its late response must be dropped.
    do_reset();
    #1;
    check("mid reset err cleared", 32'(err_o), 32'd0);
    @(negedge clk);
    m0_req_i  = 1'b1;
    m0_addr_i = 22'h500;
    mem_gnt_i = 1'b1;
    #2;
    check("mid grant", 32'(m0_gnt_o), 32'd1);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b0;
    #2;
    check("mid in reset mem_req", 32'(mem_req_o), 32'd0);
    check("mid in reset err", 32'(err_o), 32'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hCAFE_0500;
    #2;
    check("mid late m0_rvalid", 32'(m0_rvalid_o), 32'd0);
    check("mid late m1_rvalid", 32'(m1_rvalid_o), 32'd0);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #2;
    check("mid err set", 32'(err_o), 32'd1);
    @(negedge clk);
    m1_req_i  = 1'b1;
    m1_addr_i = 22'h600;
    mem_gnt_i = 1'b1;
    #2;
    check("post reset m1_gnt", 32'(m1_gnt_o), 32'd1);
    @(negedge clk);
    m1_req_i     = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0000_0600;
    #2;
    check("post reset m1_rvalid", 32'(m1_rvalid_o), 32'd1);
    check("post reset m0_rvalid", 32'(m0_rvalid_o), 32'd0);
    check("post reset m1_rdata", m1_rdata_o, 32'h0000_0600);
    @(negedge clk);
    mem_rvalid_i = 1'b1;
    #2;
    check("post reset fifo empty m0", 32'(m0_rvalid_o), 32'd0);
    check("post reset fifo empty m1", 32'(m1_rvalid_o), 32'd0);
    @(negedge clk);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
